// File: rtl/calc_pkg.sv
// Shared definitions for the sign-magnitude display path: FSM states,
// 7-segment glyphs (bit0 = a .. bit6 = g) and one-hot digit enables.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    localparam logic [6:0] SEG_D0 = 7'b0111111;
    localparam logic [6:0] SEG_D1 = 7'b0000110;
    localparam logic [6:0] SEG_D2 = 7'b1011011;
    localparam logic [6:0] SEG_D3 = 7'b1001111;
    localparam logic [6:0] SEG_D4 = 7'b1100110;
    localparam logic [6:0] SEG_D5 = 7'b1101101;
    localparam logic [6:0] SEG_D6 = 7'b1111101;
    localparam logic [6:0] SEG_D7 = 7'b0000111;

    localparam logic [1:0] DIG_NONE = 2'b00;
    localparam logic [1:0] DIG_MAG  = 2'b01;
    localparam logic [1:0] DIG_SIGN = 2'b10;

    // Negative zero carries no minus sign.
    function automatic logic is_neg(input logic [3:0] value);
        return value[3] && (value[2:0] != 3'd0);
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 3-bit magnitude to 7-segment glyph decoder.
module seg7_dec
    import calc_pkg::*;
(
    input  logic [2:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default assignment first so every path drives seg and no latch is inferred.
        seg = SEG_BLANK;
        case (digit)
            3'd0: seg = SEG_D0;
            3'd1: seg = SEG_D1;
            3'd2: seg = SEG_D2;
            3'd3: seg = SEG_D3;
            3'd4: seg = SEG_D4;
            3'd5: seg = SEG_D5;
            3'd6: seg = SEG_D6;
            3'd7: seg = SEG_D7;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sm_disp_scan.sv
// Two-digit multiplexed display of a sign-magnitude value with valid/ready capture.
// Optional blink-after-load behaviour is enabled by defining DISP_BLINK_EN.
module sm_disp_scan
    import calc_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] sm_in,
    output logic [6:0] seg,
    output logic [1:0] dig_en
);

    localparam logic [15:0] CNT_MAX = 16'(DIV - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  hold_reg;
    logic [15:0] cnt;
    logic        slot_sel;
    logic        wrap;
    logic        xfer;
    logic        blink_off;
    logic        ready_nxt;
    logic [6:0]  glyph;
    logic [6:0]  seg_nxt;
    logic [1:0]  dig_nxt;

    assign xfer = in_valid & in_ready;
    assign wrap = (cnt == CNT_MAX);

    seg7_dec u_dec (
        .digit (hold_reg[2:0]),
        .seg   (glyph)
    );

    // NOTE: every register resets asynchronously so the outputs blank the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = LOAD;
            LOAD:    state_nxt = SHOW;
            SHOW:    if (xfer) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= 4'd0;
            cnt      <= 16'd0;
            slot_sel <= 1'b0;
        end else begin
            if (xfer) hold_reg <= sm_in;
            if (wrap) begin
                cnt      <= 16'd0;
                slot_sel <= ~slot_sel;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

`ifdef DISP_BLINK_EN
    localparam logic [3:0] BLINK_PAIRS = 4'd8;

    logic [3:0] pair_cnt;

    // A slot-pair ends when the sign slot wraps back to the magnitude slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt <= 4'd0;
        end else if (xfer) begin
            pair_cnt <= 4'd0;
        end else if (wrap && slot_sel && (pair_cnt != BLINK_PAIRS)) begin
            pair_cnt <= pair_cnt + 4'd1;
        end
    end

    assign blink_off = (pair_cnt != BLINK_PAIRS) && pair_cnt[0];
`else
    assign blink_off = 1'b0;
`endif

    // Display is computed from the current hold_reg and registered, so LOAD
    // still shows the previous value while LOAD-from-IDLE stays blank.
    always_comb begin
        ready_nxt = (state_nxt != LOAD);
        seg_nxt   = SEG_BLANK;
        dig_nxt   = DIG_NONE;
        if ((state != IDLE) && !blink_off) begin
            if (!slot_sel) begin
                dig_nxt = DIG_MAG;
                seg_nxt = glyph;
            end else begin
                dig_nxt = DIG_SIGN;
                seg_nxt = is_neg(hold_reg) ? SEG_MINUS : SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            seg      <= SEG_BLANK;
            dig_en   <= DIG_NONE;
        end else begin
            in_ready <= ready_nxt;
            seg      <= seg_nxt;
            dig_en   <= dig_nxt;
        end
    end

endmodule
